// File: rtl/lfsr_noise_bank_pkg.sv
// rtl/lfsr_noise_bank_pkg.sv - shared constants and LFSR helper functions for the noise bank
package noise_pkg;

  localparam logic [31:0] GOLDEN       = 32'h9E37_79B9;
  localparam logic [31:0] DEFAULT_TAPS = 32'h0000_00C4;
  localparam logic [31:0] DEFAULT_SEED = 32'hABAB_ABAB;

  // Mask covering the low `width` bits of a 32-bit word.
  function automatic logic [31:0] width_mask(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  // One Galois step: the MSB recirculates into bit 0 and is XORed into every tapped bit above 0.
  function automatic logic [31:0] galois_step(input logic [31:0] sr, input logic [31:0] taps,
                                              input int width);
    logic        b;
    logic [31:0] nxt;
    b   = sr[5'(width - 1)];
    nxt = ((sr << 1) | {31'd0, b}) ^ ({32{b}} & taps & ~32'd1);
    return nxt & width_mask(width);
  endfunction

  // Per-channel seed spread by the golden-ratio constant; an all-zero state would lock up, so use 1.
  function automatic logic [31:0] chan_seed(input logic [31:0] seed, input int c, input int width);
    logic [31:0] s;
    s = (seed ^ (32'(c) * GOLDEN)) & width_mask(width);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/lfsr_noise_bank_if.sv
// rtl/lfsr_noise_bank_if.sv - control, reseed and output stream bundle of the noise bank
interface lfsr_noise_bank_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int OUT_BITS = 8,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                         enable;
  logic                         seed_load;
  logic [SEL_W-1:0]             seed_chan;
  logic [WIDTH-1:0]             seed_value;
  logic [CHANNELS*OUT_BITS-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [CHANNELS-1:0]          random_bits;
  logic                         seed_err;

  modport master (
    input  enable, seed_load, seed_chan, seed_value, out_ready,
    output out_data, out_valid, random_bits, seed_err
  );

  modport slave (
    output enable, seed_load, seed_chan, seed_value, out_ready,
    input  out_data, out_valid, random_bits, seed_err
  );
endinterface

// File: rtl/lfsr_noise_bank_lfsr_galois.sv
// rtl/lfsr_noise_bank_lfsr_galois.sv - single Galois LFSR channel with step and reseed
module lfsr_galois
  import noise_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] TAPS  = DEFAULT_TAPS,
  parameter logic [31:0] INIT  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state,
  output logic             msb
);

  // reseed wins over stepping; a zero reseed is replaced by 1 so the register never locks
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= WIDTH'(INIT);
    end else if (load) begin
      state <= (load_value == '0) ? WIDTH'(1) : load_value;
    end else if (step) begin
      state <= WIDTH'(galois_step(32'(state), TAPS, WIDTH));
    end
  end

  assign msb = state[WIDTH-1];

endmodule

// File: rtl/lfsr_noise_bank.sv
// rtl/lfsr_noise_bank.sv - multi-channel LFSR noise bank packing serial bits into valid/ready words
module lfsr_noise_bank
  import noise_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] TAPS     = DEFAULT_TAPS,
  parameter logic [31:0] SEED     = DEFAULT_SEED,
  parameter int          CHANNELS = 4,
  parameter int          OUT_BITS = 8
) (
  input logic               clk,
  input logic               reset,
  lfsr_noise_bank_if.master bus
);

  localparam int               CNT_W    = $clog2(OUT_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_BITS);

  logic [CNT_W-1:0]             cnt;
  logic [OUT_BITS-1:0]          acc [CHANNELS];
  logic [CHANNELS*OUT_BITS-1:0] acc_flat;
  logic [WIDTH-1:0]             lfsr_state [CHANNELS];
  logic [CHANNELS-1:0]          msb;
  logic [CHANNELS-1:0]          load_sel;
  logic                         load_hit;
  logic                         full;
  logic                         hold;
  logic                         step;
  logic                         xfer;

  // An out-of-range channel makes the whole strobe a no-op, so it neither stalls nor clears cnt.
  assign load_hit = bus.seed_load && (32'(bus.seed_chan) < CHANNELS);
  assign load_sel = load_hit ? (CHANNELS'(1) << bus.seed_chan) : '0;
  assign full     = (cnt == CNT_FULL);
  // Full accumulators with an unaccepted word in the output register: freeze every channel.
  assign hold     = full && bus.out_valid && !bus.out_ready;
  assign step     = bus.enable && !load_hit && !hold;
  assign xfer     = full && (!bus.out_valid || bus.out_ready);

  assign bus.random_bits = msb;

  // flatten the per-channel accumulators into output word layout
  always_comb begin
    acc_flat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_flat[c*OUT_BITS +: OUT_BITS] = acc[c];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    lfsr_galois #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .INIT  (chan_seed(SEED, c, WIDTH))
    ) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .step       (step),
      .load       (load_sel[c]),
      .load_value (bus.seed_value),
      .state      (lfsr_state[c]),
      .msb        (msb[c])
    );

    // a live channel must never reach the all-zero lock-up state
    always_ff @(posedge clk) begin
      if (reset) begin
        assert (lfsr_state[c] != '0);
      end
    end
  end

  // shared bit counter, accumulators, output register and reseed error pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.seed_err  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
      end
    end else begin
      bus.seed_err <= load_hit && (bus.seed_value == '0);

      if (xfer) begin
        bus.out_data  <= acc_flat;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      // a transfer restarts the word; a step in the same cycle becomes its first bit
      if (load_hit) begin
        cnt <= '0;
      end else if (xfer) begin
        cnt <= step ? CNT_W'(1) : '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end

      if (step) begin
        for (int c = 0; c < CHANNELS; c++) begin
          acc[c] <= (acc[c] << 1) | OUT_BITS'(msb[c]);
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_noise_bank.sv
// tb/tb_lfsr_noise_bank.sv - scoreboard bench for the LFSR noise bank (default and 16-bit single-channel builds)
module tb_lfsr_noise_bank;

  logic clk;
  logic reset_a;
  logic reset_b;

  int compared   = 0;
  int mismatched = 0;
  int acc_a      = 0;
  int acc_b      = 0;

  logic [31:0] sb_a [$];
  logic [15:0] sb_b [$];
  logic [31:0] ma [4];
  logic [31:0] mb;

  lfsr_noise_bank_if #(.WIDTH(32), .CHANNELS(4), .OUT_BITS(8))  ifa ();
  lfsr_noise_bank_if #(.WIDTH(16), .CHANNELS(1), .OUT_BITS(16)) ifb ();

  lfsr_noise_bank #(
    .WIDTH(32), .TAPS(32'h0000_00C4), .SEED(32'hABAB_ABAB), .CHANNELS(4), .OUT_BITS(8)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (ifa)
  );

  lfsr_noise_bank #(
    .WIDTH(16), .TAPS(32'h0000_002C), .SEED(32'hABAB_ABAB), .CHANNELS(1), .OUT_BITS(16)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // reference Galois step written bit by bit
  function automatic logic [31:0] m_step(input logic [31:0] s, input int w, input logic [31:0] taps);
    logic [31:0] n;
    logic        b;
    b    = s[w-1];
    n    = '0;
    n[0] = b;
    for (int i = 1; i < w; i++) n[i] = s[i-1] ^ (b & taps[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_seed(input int c, input int w);
    logic [31:0] s;
    s = 32'hABAB_ABAB ^ (32'(c) * 32'h9E37_79B9);
    if (w < 32) s = s & ((32'd1 << w) - 32'd1);
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

  task automatic push_a(input int n);
    logic [31:0] word;
    logic [7:0]  w8;
    for (int k = 0; k < n; k++) begin
      word = '0;
      for (int c = 0; c < 4; c++) begin
        w8 = '0;
        for (int i = 0; i < 8; i++) begin
          w8    = {w8[6:0], ma[c][31]};
          ma[c] = m_step(ma[c], 32, 32'h0000_00C4);
        end
        word[c*8 +: 8] = w8;
      end
      sb_a.push_back(word);
    end
  endtask

  task automatic push_b(input int n);
    logic [15:0] w16;
    for (int k = 0; k < n; k++) begin
      w16 = '0;
      for (int i = 0; i < 16; i++) begin
        w16 = {w16[14:0], mb[15]};
        mb  = m_step(mb, 16, 32'h0000_002C);
      end
      sb_b.push_back(w16);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a_seq();
    ifa.enable    = 1'b0;
    ifa.out_ready = 1'b0;
    ifa.seed_load = 1'b0;
    reset_a       = 1'b0;
    tick();
    tick();
    sb_a.delete();
    acc_a = 0;
    for (int c = 0; c < 4; c++) ma[c] = m_seed(c, 32);
    reset_a = 1'b1;
  endtask

  task automatic reset_b_seq();
    ifb.enable    = 1'b0;
    ifb.out_ready = 1'b0;
    ifb.seed_load = 1'b0;
    reset_b       = 1'b0;
    tick();
    tick();
    sb_b.delete();
    acc_b = 0;
    mb    = m_seed(0, 16);
    reset_b = 1'b1;
  endtask

  task automatic wait_valid_a(input int maxc);
    int n;
    n = 0;
    while (!ifa.out_valid && n < maxc) begin
      tick();
      n++;
    end
    if (!ifa.out_valid) begin
      compared++;
      mismatched++;
      $display("FAIL wait_valid_a timeout after %0d cycles", maxc);
    end
  endtask

  // monitor: every accepted word is popped from its scoreboard and compared
  always @(negedge clk) begin
    if (reset_a && ifa.out_valid && ifa.out_ready) begin
      acc_a++;
      if (sb_a.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL word_a unexpected actual=%h required=none", ifa.out_data);
      end else begin
        chk("word_a", 64'(ifa.out_data), 64'(sb_a.pop_front()));
      end
    end
    if (reset_b && ifb.out_valid && ifb.out_ready) begin
      acc_b++;
      if (sb_b.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL word_b unexpected actual=%h required=none", ifb.out_data);
      end else begin
        chk("word_b", 64'(ifb.out_data), 64'(sb_b.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] snap_data;
    logic [3:0]  snap_rb;

    reset_a        = 1'b0;
    reset_b        = 1'b0;
    ifa.enable     = 1'b0;
    ifa.seed_load  = 1'b0;
    ifa.seed_chan  = '0;
    ifa.seed_value = '0;
    ifa.out_ready  = 1'b0;
    ifb.enable     = 1'b0;
    ifb.seed_load  = 1'b0;
    ifb.seed_chan  = '0;
    ifb.seed_value = '0;
    ifb.out_ready  = 1'b0;

    // 1: reset state, first-word latency, sustained stream
    reset_a_seq();
    chk("reset_valid", 64'(ifa.out_valid), 64'd0);
    chk("reset_data", 64'(ifa.out_data), 64'd0);
    chk("reset_seed_err", 64'(ifa.seed_err), 64'd0);
    chk("reset_random_bits", 64'(ifa.random_bits), 64'h5);
    ifa.enable    = 1'b1;
    ifa.out_ready = 1'b1;
    push_a(120);
    repeat (8) tick();
    chk("valid_before_cycle9", 64'(ifa.out_valid), 64'd0);
    tick();
    chk("first_valid", 64'(ifa.out_valid), 64'd1);
    chk("first_word", 64'(ifa.out_data), 64'h7197_35AB);
    repeat (900) tick();
    chk("sustained_word_count", 64'(acc_a), 64'd113);

    // 2: backpressure after the first word
    reset_a_seq();
    ifa.enable = 1'b1;
    push_a(40);
    repeat (17) tick();
    snap_data = ifa.out_data;
    snap_rb   = ifa.random_bits;
    chk("held_first_word", 64'(snap_data), 64'h7197_35AB);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("hold_stable", {27'd0, ifa.out_valid, ifa.random_bits, ifa.out_data},
          {27'd0, 1'b1, snap_rb, snap_data});
    end
    ifa.out_ready = 1'b1;
    repeat (200) tick();
    chk("release_words_ge20", 64'(acc_a >= 20), 64'd1);

    // 3: reseed channel 2 at cnt=5
    reset_a_seq();
    ifa.enable    = 1'b1;
    ifa.out_ready = 1'b1;
    push_a(1);
    repeat (13) tick();
    ifa.seed_load  = 1'b1;
    ifa.seed_chan  = 2'd2;
    ifa.seed_value = 32'hFF00_0000;
    tick();
    ifa.seed_load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) ma[c] = 32'hFF00_0000;
      else for (int i = 0; i < 5; i++) ma[c] = m_step(ma[c], 32, 32'h0000_00C4);
    end
    push_a(30);
    wait_valid_a(20);
    chk("reseed_ch2_word", 64'(ifa.out_data[23:16]), 64'hFF);
    repeat (150) tick();

    // 4: zero reseed on channel 1
    reset_a_seq();
    ifa.enable     = 1'b1;
    ifa.out_ready  = 1'b1;
    ifa.seed_load  = 1'b1;
    ifa.seed_chan  = 2'd1;
    ifa.seed_value = 32'd0;
    chk("seed_err_before", 64'(ifa.seed_err), 64'd0);
    tick();
    chk("seed_err_pulse", 64'(ifa.seed_err), 64'd1);
    ifa.seed_load = 1'b0;
    tick();
    chk("seed_err_one_cycle", 64'(ifa.seed_err), 64'd0);
    ma[1] = 32'd1;
    push_a(30);
    wait_valid_a(20);
    chk("zero_seed_ch1_word", 64'(ifa.out_data[15:8]), 64'h00);
    repeat (150) tick();

    // 5: reset while a word is held
    reset_a_seq();
    ifa.enable = 1'b1;
    repeat (20) tick();
    chk("p5_valid_held", 64'(ifa.out_valid), 64'd1);
    reset_a = 1'b0;
    tick();
    chk("p5_reset_drops_word", {31'd0, ifa.out_valid, ifa.out_data}, 64'd0);
    reset_a_seq();
    ifa.enable    = 1'b1;
    ifa.out_ready = 1'b1;
    push_a(20);
    repeat (9) tick();
    chk("p5_restart_word", 64'(ifa.out_data), 64'h7197_35AB);
    repeat (100) tick();

    // 6: random enable and backpressure
    reset_a_seq();
    push_a(200);
    for (int i = 0; i < 1500; i++) begin
      ifa.enable    = 1'($urandom_range(0, 1));
      ifa.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("random_words_ge20", 64'(acc_a >= 20), 64'd1);
    reset_a_seq();

    // 16-bit single-channel build: latency, random ready, out-of-range reseed ignored
    reset_b_seq();
    ifb.enable    = 1'b1;
    ifb.out_ready = 1'b1;
    push_b(60);
    repeat (16) tick();
    chk("b_valid_before_17", 64'(ifb.out_valid), 64'd0);
    tick();
    chk("b_first_valid", 64'(ifb.out_valid), 64'd1);
    for (int i = 0; i < 700; i++) begin
      ifb.out_ready = 1'($urandom_range(0, 1));
      if (i == 100) begin
        ifb.seed_load  = 1'b1;
        ifb.seed_chan  = 1'b1;
        ifb.seed_value = 16'd0;
      end else begin
        ifb.seed_load = 1'b0;
      end
      tick();
      if (i == 100) chk("b_oob_no_seed_err", 64'(ifb.seed_err), 64'd0);
    end
    chk("b_words_ge15", 64'(acc_b >= 15), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
